me_sad_accumulator: RTL



---
 rtl/me_sad_accumulator.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/me_sad_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : me_sad_accumulator
// Description : Motion-estimation SAD accumulator. Each enabled beat carries
//               one row: 4 current pixels and an 8-pixel reference row. The
//               per-row SAD for 5 horizontal candidate offsets (k = 0..4) is
//               accumulated over ROWS beats. After the final beat of a block
//               the minimum SAD and its offset are emitted as a one-cycle
//               pulse.
//
// Pipeline    : E1 abs differences + last-row flag
//               E2 accumulate (load on first row), saturating
//               E3 minimum search (lowest k wins ties)
//               OUT registered outputs + sad_valid_o pulse
//               sad_valid_o rises 3 edges after the edge sampling the final beat.
//
// Ports       : clk          system clock, rising edge
//               rst_n        asynchronous active-low reset
//               en_i         beat valid
//               cur_in_i     4 current pixels, pixel i at [8i+7:8i]
//               ref_in_i     8 reference pixels, pixel j at [8j+7:8j]
//               clr_i        synchronous abort of the partial block
//               sad_valid_o  one-cycle result pulse
//               best_mv_o    winning offset k (0..4)
//               best_sad_o   winning accumulated SAD
//               busy_o       block partially accumulated or result in flight
//               sad_all_o    (ME_SAD_ALL_OUT_EN only) all 5 SADs, k at
//                            [SAD_W*k +: SAD_W]
//
// Options     : define ME_SAD_ALL_OUT_EN to add the sad_all_o output.
//
// Revision    : 1.0  initial release
// ============================================================================
module me_sad_accumulator #(
  parameter int ROWS  = 4,
  parameter int SAD_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [31:0]        cur_in_i,
  input  logic [63:0]        ref_in_i,
  input  logic               clr_i,
  output logic               sad_valid_o,
  output logic [2:0]         best_mv_o,
  output logic [SAD_W-1:0]   best_sad_o,
  output logic               busy_o
`ifdef ME_SAD_ALL_OUT_EN
  ,
  output logic [5*SAD_W-1:0] sad_all_o
`endif
);

  localparam int                 c_CNT_W    = $clog2(ROWS);
  localparam int                 c_SUM_W    = SAD_W + 1;
  localparam logic [c_CNT_W-1:0] c_LAST_ROW = c_CNT_W'(ROWS - 1);
  localparam logic [SAD_W-1:0]   c_SAD_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic [c_CNT_W-1:0] r_row;
  logic [c_CNT_W-1:0] w_row_next;

  logic               w_beat;
  logic               w_final_beat;
  logic               w_e1_keep;
  logic               w_in_flight;

  logic [7:0]         r_diff [5][4];
  logic               r_e1_valid;
  logic               r_e1_first;
  logic               r_e1_last;

  logic [9:0]         w_row_sum  [5];
  logic [c_SUM_W-1:0] w_acc_sum  [5];
  logic [SAD_W-1:0]   w_acc_next [5];
  logic [SAD_W-1:0]   r_acc      [5];
  logic               r_e2_last;

  logic [2:0]         w_best_mv;
  logic [SAD_W-1:0]   w_best_sad;
  logic               r_e3_valid;
  logic [2:0]         r_e3_mv;
  logic [SAD_W-1:0]   r_e3_sad;

  // clr_i wins over en_i: a beat arriving with clr_i is dropped.
  assign w_beat       = en_i & ~clr_i;
  assign w_final_beat = w_beat & (r_row == c_LAST_ROW);

  // A beat in E1 survives clr_i only if it is the final beat of its block;
  // non-final partial work is killed.
  assign w_e1_keep    = r_e1_valid & (r_e1_last | ~clr_i);

  always_comb begin
    w_row_next = r_row;
    if (clr_i) begin
      w_row_next = '0;
    end else if (w_beat) begin
      w_row_next = (r_row == c_LAST_ROW) ? '0 : r_row + c_CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Block-level FSM: ACCUM while a partial block exists, FLUSH while a
  // completed block is still travelling towards (or being shown as) its pulse.
  // A new block starting during a flush takes precedence (ACCUM).
  // --------------------------------------------------------------------------
  assign w_in_flight = w_final_beat | (w_e1_keep & r_e1_last) | r_e2_last | r_e3_valid;

  always_comb begin
    w_state_next = S_IDLE;
    if (w_row_next != '0) begin
      w_state_next = S_ACCUM;
    end else if (w_in_flight) begin
      w_state_next = S_FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
    end
  end

  assign busy_o = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // E1: absolute differences |cur[i] - ref[i+k]|
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e1_valid <= 1'b0;
      r_e1_first <= 1'b0;
      r_e1_last  <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        for (int i = 0; i < 4; i++) begin
          r_diff[k][i] <= '0;
        end
      end
    end else begin
      r_e1_valid <= w_beat;
      if (w_beat) begin
        r_e1_first <= (r_row == '0);
        r_e1_last  <= (r_row == c_LAST_ROW);
        for (int k = 0; k < 5; k++) begin
          for (int i = 0; i < 4; i++) begin
            r_diff[k][i] <= abs_diff(cur_in_i[8*i +: 8], ref_in_i[8*(i+k) +: 8]);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // E2: row sums and saturating accumulation
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < 5; k++) begin : g_cand
    assign w_row_sum[k]  = 10'(r_diff[k][0]) + 10'(r_diff[k][1])
                         + 10'(r_diff[k][2]) + 10'(r_diff[k][3]);
    assign w_acc_sum[k]  = {1'b0, r_acc[k]} + c_SUM_W'(w_row_sum[k]);
    assign w_acc_next[k] = r_e1_first           ? SAD_W'(w_row_sum[k]) :
                           w_acc_sum[k][SAD_W]  ? c_SAD_MAX            :
                                                  w_acc_sum[k][SAD_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e2_last <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        r_acc[k] <= '0;
      end
    end else begin
      r_e2_last <= w_e1_keep & r_e1_last;
      if (w_e1_keep) begin
        for (int k = 0; k < 5; k++) begin
          r_acc[k] <= w_acc_next[k];
        end
      end else if (clr_i) begin
        // Any completed block has already been captured by E3 at this edge.
        for (int k = 0; k < 5; k++) begin
          r_acc[k] <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // E3: minimum search; strict less-than keeps the lowest k on ties
  // --------------------------------------------------------------------------
  always_comb begin
    w_best_mv  = 3'd0;
    w_best_sad = r_acc[0];
    for (int k = 1; k < 5; k++) begin
      if (r_acc[k] < w_best_sad) begin
        w_best_sad = r_acc[k];
        w_best_mv  = 3'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e3_valid <= 1'b0;
      r_e3_mv    <= '0;
      r_e3_sad   <= '0;
    end else begin
      r_e3_valid <= r_e2_last;
      if (r_e2_last) begin
        r_e3_mv  <= w_best_mv;
        r_e3_sad <= w_best_sad;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output registers: results hold between pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_valid_o <= 1'b0;
      best_mv_o   <= '0;
      best_sad_o  <= '0;
    end else begin
      sad_valid_o <= r_e3_valid;
      if (r_e3_valid) begin
        best_mv_o  <= r_e3_mv;
        best_sad_o <= r_e3_sad;
      end
    end
  end

`ifdef ME_SAD_ALL_OUT_EN
  logic [5*SAD_W-1:0] w_acc_all;
  logic [5*SAD_W-1:0] r_e3_all;

  for (genvar k = 0; k < 5; k++) begin : g_pack
    assign w_acc_all[SAD_W*k +: SAD_W] = r_acc[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e3_all  <= '0;
      sad_all_o <= '0;
    end else begin
      if (r_e2_last) begin
        r_e3_all <= w_acc_all;
      end
      if (r_e3_valid) begin
        sad_all_o <= r_e3_all;
      end
    end
  end
`endif

endmodule
`default_nettype wire
